// File: rtl/boot_seq_ctrl.sv
// boot_seq_ctrl: qualifies PLL lock, then releases NUM_STAGES reset domains one at a time in order.
// Latency: first release LOCK_FILT+STAGE_DLY cycles after lock; each later release STAGE_DLY after the previous ack.
// Backpressure: each stage holds on its level ack; under BOOT_ACK_TIMEOUT_EN it gives up after ACK_TMO cycles.
//
// Optional feature macro: BOOT_ACK_TIMEOUT_EN (per-stage ack timeout, sticky o_err flags).
// Ports: i_clk, i_rst (synchronous, active-high); i_locked lock inputs (ANDed); i_soft_rst restart pulse;
//   i_stage_ack per-domain init-done level; o_rst_n per-domain active-low reset; o_boot_done all stages up;
//   o_state / o_stage debug status; o_err sticky per-stage timeout flags.
module boot_seq_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int LOCK_W     = 2,
  parameter int LOCK_FILT  = 16,
  parameter int STAGE_DLY  = 256,
  parameter int ACK_TMO    = 65535
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [LOCK_W-1:0]     i_locked,
  input  logic                  i_soft_rst,
  input  logic [NUM_STAGES-1:0] i_stage_ack,
  output logic [NUM_STAGES-1:0] o_rst_n,
  output logic                  o_boot_done,
  output logic [2:0]            o_state,
  output logic [2:0]            o_stage,
  output logic [NUM_STAGES-1:0] o_err
);

  localparam int         FILT_W     = $clog2(LOCK_FILT + 1);
  localparam int         DLY_W      = $clog2(STAGE_DLY + 1);
  localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_FILTER    = 3'd1,
    ST_DELAY     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [FILT_W-1:0]     filt_q, filt_d;
  logic [DLY_W-1:0]      dly_q, dly_d;
  logic [2:0]            stage_q, stage_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic                  done_q, done_d;
  logic [NUM_STAGES-1:0] stage_oh;
  logic                  lock_ok, abort, ack_cur, advance;

`ifdef BOOT_ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(ACK_TMO + 1);
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [NUM_STAGES-1:0] err_q, err_d;
  logic                  tmo_hit;
`else
  // ACK_TMO only matters when the timeout is built in.
  logic unused_tmo;
  assign unused_tmo = (ACK_TMO == 0);
`endif

  // One-hot of the current stage: selects its ack and the reset bit to release.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      stage_oh[k] = (stage_q == 3'(k));
    end
  end

  assign lock_ok = &i_locked;
  assign ack_cur = |(i_stage_ack & stage_oh);
  // WAIT_LOCK is already the restart point, so nothing there can abort.
  assign abort   = (state_q != ST_WAIT_LOCK) && (!lock_ok || i_soft_rst);

`ifdef BOOT_ACK_TIMEOUT_EN
  assign tmo_hit = (state_q == ST_WAIT_ACK) && !ack_cur && (tmo_q >= TMO_W'(ACK_TMO - 1));
  assign advance = ack_cur || tmo_hit;
`else
  assign advance = ack_cur;
`endif

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    dly_d   = dly_q;
    stage_d = stage_q;
    rst_n_d = rst_n_q;
    // boot_done lags DONE by one cycle so it reflects a settled final state.
    done_d  = (state_q == ST_DONE);
`ifdef BOOT_ACK_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    if (abort) begin
      state_d = ST_WAIT_LOCK;
      filt_d  = '0;
      dly_d   = '0;
      stage_d = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
`ifdef BOOT_ACK_TIMEOUT_EN
      tmo_d   = '0;
`endif
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          // The exit edge is the first good lock sample.
          if (lock_ok) begin
            if (LOCK_FILT <= 1) begin
              state_d = ST_DELAY;
            end else begin
              state_d = ST_FILTER;
              filt_d  = FILT_W'(1);
            end
          end
        end
        ST_FILTER: begin
          // Lock is known high here; a low sample takes the abort path.
          if (filt_q >= FILT_W'(LOCK_FILT - 1)) begin
            state_d = ST_DELAY;
            filt_d  = '0;
            dly_d   = '0;
            stage_d = '0;
          end else begin
            filt_d = filt_q + 1'b1;
          end
        end
        ST_DELAY: begin
          if (dly_q >= DLY_W'(STAGE_DLY - 1)) begin
            rst_n_d = rst_n_q | stage_oh;
            dly_d   = '0;
            state_d = ST_WAIT_ACK;
`ifdef BOOT_ACK_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
        ST_WAIT_ACK: begin
`ifdef BOOT_ACK_TIMEOUT_EN
          if (tmo_hit) begin
            err_d = err_q | stage_oh;
          end
          tmo_d = advance ? '0 : tmo_q + 1'b1;
`endif
          if (advance) begin
            if (stage_q == LAST_STAGE) begin
              state_d = ST_DONE;
            end else begin
              stage_d = stage_q + 3'd1;
              state_d = ST_DELAY;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_WAIT_LOCK;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_WAIT_LOCK;
      filt_q  <= '0;
      dly_q   <= '0;
      stage_q <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
`ifdef BOOT_ACK_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      dly_q   <= dly_d;
      stage_q <= stage_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
`ifdef BOOT_ACK_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign o_rst_n     = rst_n_q;
  assign o_boot_done = done_q;
  assign o_state     = state_q;
  assign o_stage     = stage_q;
`ifdef BOOT_ACK_TIMEOUT_EN
  assign o_err       = err_q;
`else
  assign o_err       = '0;
`endif

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// tb_boot_seq_ctrl: directed scenarios with randomized ack timing and lock/abort points,
// checked every cycle against a timestamp-based reference model of the boot sequence.
module tb_boot_seq_ctrl;

  localparam int NS  = 4;
  localparam int LW  = 2;
  localparam int LF  = 4;
  localparam int SD  = 8;
  localparam int TMO = 20;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [LW-1:0] i_locked;
  logic          i_soft_rst;
  logic [NS-1:0] i_stage_ack;
  logic [NS-1:0] o_rst_n;
  logic          o_boot_done;
  logic [2:0]    o_state;
  logic [2:0]    o_stage;
  logic [NS-1:0] o_err;

  always #5 i_clk = ~i_clk;

  boot_seq_ctrl #(
    .NUM_STAGES(NS),
    .LOCK_W    (LW),
    .LOCK_FILT (LF),
    .STAGE_DLY (SD),
    .ACK_TMO   (TMO)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_locked   (i_locked),
    .i_soft_rst (i_soft_rst),
    .i_stage_ack(i_stage_ack),
    .o_rst_n    (o_rst_n),
    .o_boot_done(o_boot_done),
    .o_state    (o_state),
    .o_stage    (o_stage),
    .o_err      (o_err)
  );

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // Reference model: the sequence is described by when it started, how many
  // stages have been released / acknowledged, and when the next release is due.
  bit            seq_on    = 1'b0;
  int            seq_start = 0;
  int            n_rel     = 0;
  int            n_ack     = 0;
  int            next_rel  = 0;
  bit            done_m    = 1'b0;
  logic [NS-1:0] err_m     = '0;
  int            rel_edge[NS];
  int            ack_dly[NS];
  logic [NS-1:0] auto_mask = '0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic model_edge();
    if (i_rst) begin
      seq_on = 1'b0; n_rel = 0; n_ack = 0; done_m = 1'b0; err_m = '0;
    end else if (seq_on && (!(&i_locked) || i_soft_rst)) begin
      seq_on = 1'b0; n_rel = 0; n_ack = 0; done_m = 1'b0;
    end else if (!seq_on) begin
      if (&i_locked) begin
        seq_on    = 1'b1;
        seq_start = edge_n;
        next_rel  = edge_n + (LF - 1) + SD;
      end
    end else begin
      done_m = (n_ack == NS);
      if (n_rel == n_ack) begin
        if (n_rel < NS && edge_n == next_rel) begin
          rel_edge[n_rel] = edge_n;
          n_rel++;
        end
      end else begin
        bit take;
        take = i_stage_ack[n_ack];
`ifdef BOOT_ACK_TIMEOUT_EN
        if (!take && (edge_n - rel_edge[n_ack] == TMO)) begin
          err_m[n_ack] = 1'b1;
          take = 1'b1;
        end
`endif
        if (take) begin
          n_ack++;
          if (n_ack < NS) next_rel = edge_n + SD;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [NS-1:0] er;
    logic [2:0]    es;
    logic [2:0]    eg;
    for (int k = 0; k < NS; k++) er[k] = (k < n_rel);
    if (!seq_on)                        es = 3'd0;
    else if (edge_n - seq_start < LF-1) es = 3'd1;
    else if (n_ack == NS)               es = 3'd4;
    else if (n_rel > n_ack)             es = 3'd3;
    else                                es = 3'd2;
    eg = (n_ack == NS) ? 3'(NS - 1) : 3'(n_ack);
    chk("rst_n", 8'(o_rst_n), 8'(er));
    chk("boot_done", 8'(o_boot_done), 8'(done_m));
    chk("state", 8'(o_state), 8'(es));
    chk("stage", 8'(o_stage), 8'(eg));
`ifdef BOOT_ACK_TIMEOUT_EN
    chk("err", 8'(o_err), 8'(err_m));
`else
    chk("err", 8'(o_err), 8'd0);
`endif
  endtask

  // Auto-acked stages raise their ack ack_dly edges after release.
  task automatic step();
    for (int k = 0; k < NS; k++) begin
      if (auto_mask[k]) i_stage_ack[k] = (n_rel > k) && (edge_n + 1 - rel_edge[k] >= ack_dly[k]);
    end
    @(posedge i_clk);
    edge_n++;
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n = 0;
    while (o_boot_done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 8'(o_boot_done), 8'd1);
  endtask

  initial begin
    int n;
    i_rst = 1'b1; i_soft_rst = 1'b0; i_locked = '0; i_stage_ack = '0;
    for (int k = 0; k < NS; k++) begin
      ack_dly[k]  = 3;
      rel_edge[k] = 0;
    end
    repeat (3) step();

    // Nominal sequence, acks 3 edges after each release.
    i_rst = 1'b0; i_locked = '1; auto_mask = '1;
    run_until_done(200, "nominal_done");
    repeat (3) step();
    auto_mask = '0; i_stage_ack = '0;
    repeat (2) step();

    // Soft reset in DONE, then a one-cycle lock glitch at filter count 3.
    for (int k = 0; k < NS; k++) ack_dly[k] = $urandom_range(1, 6);
    auto_mask = '1;
    i_soft_rst = 1'b1; step(); i_soft_rst = 1'b0;
    repeat (3) step();
    i_locked = 2'b10; step(); i_locked = '1;
    run_until_done(200, "glitch_done");

    // Lock loss while waiting for the stage-2 ack.
    auto_mask = 4'b1011; i_stage_ack[2] = 1'b0;
    i_soft_rst = 1'b1; step(); i_soft_rst = 1'b0;
    n = 0;
    while (o_rst_n[2] !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("stage2_release", 8'(o_rst_n[2]), 8'd1);
    repeat ($urandom_range(0, 5)) step();
    i_locked[1] = 1'b0; step();
    i_locked = '1; auto_mask = '1;
    run_until_done(200, "relock_done");

    // Early ack[1] held from the start; ack[3] toggling randomly during stage 0.
    for (int k = 0; k < NS; k++) ack_dly[k] = $urandom_range(1, 4);
    auto_mask = 4'b0101; i_stage_ack[1] = 1'b1; i_stage_ack[3] = 1'b0;
    i_soft_rst = 1'b1; step(); i_soft_rst = 1'b0;
    n = 0;
    while (n_ack == 0 && n < 100) begin
      i_stage_ack[3] = 1'($urandom);
      step();
      n++;
    end
    auto_mask = 4'b1101;
    run_until_done(200, "early_ack_done");

    // Soft reset while already waiting for lock does nothing.
    i_locked = '0; step();
    i_soft_rst = 1'b1; step(); i_soft_rst = 1'b0;
    step();

    // Stage-2 ack never arrives: hang without the timeout, err + done with it.
    i_locked = '1; auto_mask = 4'b1011; i_stage_ack[2] = 1'b0;
    repeat (100) step();

    // i_rst wins over a simultaneous soft reset and clears o_err.
    i_rst = 1'b1; i_soft_rst = 1'b1; step();
    i_rst = 1'b0; i_soft_rst = 1'b0; auto_mask = '1;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
